// File: rtl/arf_sequencer_pkg.sv
// Shared types and encodings for the ARF sequencer: commands, states, ARF control codes
// and the per-state control decode.
package arf_sequencer_pkg;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_FETCH = 3'd1,
        CMD_PUSH  = 3'd2,
        CMD_POP   = 3'd3,
        CMD_JUMP  = 3'd4,
        CMD_CLEAR = 3'd5
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_F_ADDR   = 4'd1,
        ST_F_SAVE   = 4'd2,
        ST_F_INC    = 4'd3,
        ST_PUSH_DEC = 4'd4,
        ST_PUSH_WR  = 4'd5,
        ST_POP_RD   = 4'd6,
        ST_POP_INC  = 4'd7,
        ST_J_SAVE   = 4'd8,
        ST_J_LOAD   = 4'd9,
        ST_CLEAR    = 4'd10
    } state_e;

    localparam logic [1:0] FUN_CLEAR = 2'b00;
    localparam logic [1:0] FUN_LOAD  = 2'b01;
    localparam logic [1:0] FUN_DEC   = 2'b10;
    localparam logic [1:0] FUN_INC   = 2'b11;

    // r_sel bit order is {AR, SP, PC_past, PC}
    localparam logic [3:0] RSEL_NONE = 4'b0000;
    localparam logic [3:0] RSEL_PC   = 4'b0001;
    localparam logic [3:0] RSEL_PCP  = 4'b0010;
    localparam logic [3:0] RSEL_SP   = 4'b0100;
    localparam logic [3:0] RSEL_AR   = 4'b1000;
    localparam logic [3:0] RSEL_ALL  = 4'b1111;

    localparam logic [1:0] SEL_AR  = 2'b00;
    localparam logic [1:0] SEL_SP  = 2'b01;
    localparam logic [1:0] SEL_PCP = 2'b10;
    localparam logic [1:0] SEL_PC  = 2'b11;

    localparam logic ISRC_BUS = 1'b0;
    localparam logic ISRC_FB  = 1'b1;

    typedef struct packed {
        logic [3:0] r_sel;
        logic [1:0] funsel;
        logic [1:0] out_a_sel;
        logic [1:0] out_b_sel;
        logic       i_src;
        logic       mem_rd;
        logic       mem_wr;
        logic       done;
        logic       ready;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(state_e s);
        ctrl_t c;
        c.r_sel     = RSEL_NONE;
        c.funsel    = FUN_LOAD;
        c.out_a_sel = SEL_PC;
        c.out_b_sel = SEL_PC;
        c.i_src     = ISRC_BUS;
        c.mem_rd    = 1'b0;
        c.mem_wr    = 1'b0;
        c.done      = 1'b0;
        c.ready     = 1'b0;
        case (s)
            ST_IDLE: c.ready = 1'b1;
            ST_F_ADDR: c.mem_rd = 1'b1;
            ST_F_SAVE: begin
                c.i_src = ISRC_FB;
                c.r_sel = RSEL_PCP;
            end
            ST_F_INC: begin
                c.r_sel  = RSEL_PC;
                c.funsel = FUN_INC;
                c.done   = 1'b1;
            end
            ST_PUSH_DEC: begin
                c.r_sel  = RSEL_SP;
                c.funsel = FUN_DEC;
            end
            ST_PUSH_WR: begin
                c.out_a_sel = SEL_SP;
                c.mem_wr    = 1'b1;
                c.done      = 1'b1;
            end
            ST_POP_RD: begin
                c.out_a_sel = SEL_SP;
                c.mem_rd    = 1'b1;
            end
            ST_POP_INC: begin
                c.r_sel  = RSEL_SP;
                c.funsel = FUN_INC;
                c.done   = 1'b1;
            end
            ST_J_SAVE: begin
                c.i_src = ISRC_FB;
                c.r_sel = RSEL_PCP;
            end
            ST_J_LOAD: begin
                c.r_sel = RSEL_PC;
                c.done  = 1'b1;
            end
            ST_CLEAR: begin
                c.r_sel  = RSEL_ALL;
                c.funsel = FUN_CLEAR;
                c.done   = 1'b1;
            end
            default: c.ready = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/arf_depth_counter.sv
// Saturating up/down occupancy counter for the sequencer's stack, with full/empty flags.
module arf_depth_counter #(
    parameter int unsigned MAX = 16,
    parameter int unsigned W   = $clog2(MAX) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    assign full  = (count == W'(MAX));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + W'(1);
        end else if (dec && !empty) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/arf_sequencer.sv
// Command sequencer driving an address register file (AR, SP, PC_past, PC) and memory strobes.
//
// state       | meaning
// ST_IDLE     | ready for a command, idle ARF controls
// ST_F_ADDR   | fetch: read memory at PC
// ST_F_SAVE   | fetch: PC_past <= PC
// ST_F_INC    | fetch: PC <= PC + 1, done
// ST_PUSH_DEC | push: SP <= SP - 1
// ST_PUSH_WR  | push: write memory at SP, done
// ST_POP_RD   | pop: read memory at SP
// ST_POP_INC  | pop: SP <= SP + 1, done
// ST_J_SAVE   | jump: PC_past <= PC
// ST_J_LOAD   | jump: PC <= external bus, done
// ST_CLEAR    | clear all ARF registers and stack depth, done
module arf_sequencer
    import arf_sequencer_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   cmd,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   funsel,
    output logic [3:0]                   r_sel,
    output logic [1:0]                   out_a_sel,
    output logic [1:0]                   out_b_sel,
    output logic                         i_src,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [$clog2(STACK_DEPTH):0] depth
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

    state_e state;
    ctrl_t  ctrl_q;
    logic   stack_full;
    logic   stack_empty;

    arf_depth_counter #(
        .MAX (STACK_DEPTH),
        .W   (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == ST_PUSH_WR),
        .dec   (state == ST_POP_INC),
        .clr   (state == ST_CLEAR),
        .count (depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Controls are registered alongside the state so every output is a clean flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ctrl_q <= ctrl_for(ST_IDLE);
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_e'(cmd))
                            CMD_NOP: begin
                                state  <= ST_IDLE;
                                ctrl_q <= ctrl_for(ST_IDLE);
                            end
                            CMD_FETCH: begin
                                state  <= ST_F_ADDR;
                                ctrl_q <= ctrl_for(ST_F_ADDR);
                            end
                            CMD_PUSH: begin
                                if (stack_full) begin
                                    err <= 1'b1;
                                end else begin
                                    state  <= ST_PUSH_DEC;
                                    ctrl_q <= ctrl_for(ST_PUSH_DEC);
                                end
                            end
                            CMD_POP: begin
                                if (stack_empty) begin
                                    err <= 1'b1;
                                end else begin
                                    state  <= ST_POP_RD;
                                    ctrl_q <= ctrl_for(ST_POP_RD);
                                end
                            end
                            CMD_JUMP: begin
                                state  <= ST_J_SAVE;
                                ctrl_q <= ctrl_for(ST_J_SAVE);
                            end
                            CMD_CLEAR: begin
                                state  <= ST_CLEAR;
                                ctrl_q <= ctrl_for(ST_CLEAR);
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ST_F_ADDR: begin
                    state  <= ST_F_SAVE;
                    ctrl_q <= ctrl_for(ST_F_SAVE);
                end
                ST_F_SAVE: begin
                    state  <= ST_F_INC;
                    ctrl_q <= ctrl_for(ST_F_INC);
                end
                ST_PUSH_DEC: begin
                    state  <= ST_PUSH_WR;
                    ctrl_q <= ctrl_for(ST_PUSH_WR);
                end
                ST_POP_RD: begin
                    state  <= ST_POP_INC;
                    ctrl_q <= ctrl_for(ST_POP_INC);
                end
                ST_J_SAVE: begin
                    state  <= ST_J_LOAD;
                    ctrl_q <= ctrl_for(ST_J_LOAD);
                end
                default: begin
                    state  <= ST_IDLE;
                    ctrl_q <= ctrl_for(ST_IDLE);
                end
            endcase
        end
    end

    assign cmd_ready = ctrl_q.ready;
    assign done      = ctrl_q.done;
    assign funsel    = ctrl_q.funsel;
    assign r_sel     = ctrl_q.r_sel;
    assign out_a_sel = ctrl_q.out_a_sel;
    assign out_b_sel = ctrl_q.out_b_sel;
    assign i_src     = ctrl_q.i_src;
    assign mem_rd    = ctrl_q.mem_rd;
    assign mem_wr    = ctrl_q.mem_wr;

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: a behavioural ARF datapath follows the DUT controls, and a
// command-level model predicts register, depth, strobe and handshake results.
module tb_arf_sequencer;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready, done, err, i_src, mem_rd, mem_wr;
    logic [1:0] funsel, out_a_sel, out_b_sel;
    logic [3:0] r_sel;
    logic [4:0] depth;

    arf_sequencer #(.STACK_DEPTH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .done      (done),
        .err       (err),
        .funsel    (funsel),
        .r_sel     (r_sel),
        .out_a_sel (out_a_sel),
        .out_b_sel (out_b_sel),
        .i_src     (i_src),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .depth     (depth)
    );

    always #5 clk = ~clk;

    // Behavioural ARF driven by the DUT controls; it has no reset of its own.
    logic [7:0] ar, sp, pcp, pc, bus, out_a, din;
    logic       pre_en;
    logic [7:0] pre_ar, pre_sp, pre_pcp, pre_pc;

    always_comb begin
        case (out_a_sel)
            2'b00:   out_a = ar;
            2'b01:   out_a = sp;
            2'b10:   out_a = pcp;
            default: out_a = pc;
        endcase
    end
    assign din = i_src ? out_a : bus;

    function automatic logic [7:0] arf_next(logic [7:0] v, logic en, logic [1:0] f, logic [7:0] d);
        if (en !== 1'b1) return v;
        case (f)
            2'b00:   return 8'h00;
            2'b01:   return d;
            2'b10:   return v - 8'h01;
            default: return v + 8'h01;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            ar  <= pre_ar;
            sp  <= pre_sp;
            pcp <= pre_pcp;
            pc  <= pre_pc;
        end else begin
            ar  <= arf_next(ar,  r_sel[3], funsel, din);
            sp  <= arf_next(sp,  r_sel[2], funsel, din);
            pcp <= arf_next(pcp, r_sel[1], funsel, din);
            pc  <= arf_next(pc,  r_sel[0], funsel, din);
        end
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] m_ar, m_sp, m_pcp, m_pc;
    int m_depth;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string cmd_name(logic [2:0] c);
        case (c)
            3'd0: return "nop";
            3'd1: return "fetch";
            3'd2: return "push";
            3'd3: return "pop";
            3'd4: return "jump";
            3'd5: return "clear";
            default: return "undef";
        endcase
    endfunction

    task automatic preload(input logic [7:0] a, input logic [7:0] s, input logic [7:0] pp, input logic [7:0] p);
        pre_ar = a; pre_sp = s; pre_pcp = pp; pre_pc = p;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        m_ar = a; m_sp = s; m_pcp = pp; m_pc = p;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_ar"},    ar,    m_ar);
        chk({tag, "_sp"},    sp,    m_sp);
        chk({tag, "_pcp"},   pcp,   m_pcp);
        chk({tag, "_pc"},    pc,    m_pc);
        chk({tag, "_depth"}, depth, m_depth);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after the command.
    task automatic run_cmd(input logic [2:0] c);
        string nm;
        int    e_done_cyc, e_rd, e_wr, last;
        bit    e_err, e_rsel;
        logic [7:0] e_rd_a, e_wr_a;
        int    o_done_n, o_done_cyc, o_err_n, o_err_cyc, o_rd_n, o_wr_n, o_busy_ready;
        logic [7:0] o_rd_a, o_wr_a;
        logic  o_rsel, o_ready_after;

        nm = cmd_name(c);
        e_done_cyc = 0; e_rd = 0; e_wr = 0; e_err = 1'b0; e_rsel = 1'b0;
        e_rd_a = 8'h00; e_wr_a = 8'h00;
        case (c)
            3'd0: ;
            3'd1: begin
                e_done_cyc = 3; e_rd = 1; e_rd_a = m_pc; e_rsel = 1'b1;
                m_pcp = m_pc; m_pc = m_pc + 8'h01;
            end
            3'd2: begin
                if (m_depth == N) e_err = 1'b1;
                else begin
                    e_done_cyc = 2; e_wr = 1; e_rsel = 1'b1;
                    m_sp = m_sp - 8'h01; e_wr_a = m_sp; m_depth++;
                end
            end
            3'd3: begin
                if (m_depth == 0) e_err = 1'b1;
                else begin
                    e_done_cyc = 2; e_rd = 1; e_rsel = 1'b1;
                    e_rd_a = m_sp; m_sp = m_sp + 8'h01; m_depth--;
                end
            end
            3'd4: begin
                e_done_cyc = 2; e_rsel = 1'b1;
                m_pcp = m_pc; m_pc = bus;
            end
            3'd5: begin
                e_done_cyc = 1; e_rsel = 1'b1;
                m_ar = 8'h00; m_sp = 8'h00; m_pcp = 8'h00; m_pc = 8'h00; m_depth = 0;
            end
            default: e_err = 1'b1;
        endcase

        chk({nm, "_ready_before"}, cmd_ready, 1'b1);
        cmd = c;
        cmd_valid = 1'b1;
        o_done_n = 0; o_done_cyc = 0; o_err_n = 0; o_err_cyc = 0; o_rd_n = 0; o_wr_n = 0;
        o_busy_ready = 0; o_rd_a = 8'h00; o_wr_a = 8'h00; o_rsel = 1'b0; o_ready_after = 1'b0;
        last = (e_done_cyc == 0) ? 2 : e_done_cyc + 1;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cmd_valid = 1'b0;
                cmd = 3'($urandom);
            end
            if (done === 1'b1) begin o_done_n++; o_done_cyc = n; end
            if (err === 1'b1) begin o_err_n++; o_err_cyc = n; end
            if (mem_rd === 1'b1) begin o_rd_n++; o_rd_a = out_a; end
            if (mem_wr === 1'b1) begin o_wr_n++; o_wr_a = out_a; end
            if (r_sel !== 4'b0000) o_rsel = 1'b1;
            if (n < e_done_cyc && cmd_ready !== 1'b0) o_busy_ready++;
            if (n == e_done_cyc + 1) o_ready_after = cmd_ready;
        end

        chk({nm, "_done_count"}, o_done_n, (e_done_cyc != 0) ? 1 : 0);
        chk({nm, "_done_cycle"}, o_done_cyc, e_done_cyc);
        chk({nm, "_err_count"}, o_err_n, e_err ? 1 : 0);
        chk({nm, "_err_cycle"}, o_err_cyc, e_err ? 1 : 0);
        chk({nm, "_rd_count"}, o_rd_n, e_rd);
        chk({nm, "_rd_addr"}, o_rd_a, e_rd_a);
        chk({nm, "_wr_count"}, o_wr_n, e_wr);
        chk({nm, "_wr_addr"}, o_wr_a, e_wr_a);
        chk({nm, "_rsel_activity"}, o_rsel, e_rsel);
        chk({nm, "_busy_not_ready"}, o_busy_ready, 0);
        chk({nm, "_ready_after"}, o_ready_after, 1'b1);
        check_regs(nm);
    endtask

    task automatic check_idle_controls(input string tag);
        chk({tag, "_ready"},  cmd_ready, 1'b1);
        chk({tag, "_done"},   done,      1'b0);
        chk({tag, "_err"},    err,       1'b0);
        chk({tag, "_rsel"},   r_sel,     4'b0000);
        chk({tag, "_funsel"}, funsel,    2'b01);
        chk({tag, "_outa"},   out_a_sel, 2'b11);
        chk({tag, "_outb"},   out_b_sel, 2'b11);
        chk({tag, "_isrc"},   i_src,     1'b0);
        chk({tag, "_memrd"},  mem_rd,    1'b0);
        chk({tag, "_memwr"},  mem_wr,    1'b0);
        chk({tag, "_depth"},  depth,     5'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd = 3'd0; cmd_valid = 1'b0; bus = 8'h00;
        pre_en = 1'b1; pre_ar = 8'h5A; pre_sp = 8'h33; pre_pcp = 8'h44; pre_pc = 8'h10;
        m_depth = 0;
        repeat (3) @(negedge clk);
        check_idle_controls("reset");
        rst_n = 1'b1;
        preload(8'h5A, 8'h33, 8'h44, 8'h10);

        // CLEAR right after reset
        run_cmd(3'd5);
        chk("clear_depth_zero", depth, 5'd0);

        // FETCH from PC=0x10, JUMP to bus value
        preload(8'h01, 8'h20, 8'h00, 8'h10);
        run_cmd(3'd1);
        chk("fetch_pc_value", pc, 8'h11);
        preload(8'h01, 8'h20, 8'h00, 8'h05);
        bus = 8'h80;
        run_cmd(3'd4);
        chk("jump_pc_value", pc, 8'h80);
        chk("jump_pcp_value", pcp, 8'h05);

        // Pop when empty, then push/pop restores SP
        run_cmd(3'd3);
        preload(8'h00, 8'h40, 8'h00, 8'h00);
        run_cmd(3'd2);
        run_cmd(3'd3);
        chk("pushpop_sp", sp, 8'h40);

        // Fill the stack from SP=0x20 then overflow
        preload(8'h00, 8'h20, 8'h00, 8'h00);
        for (int i = 0; i < N; i++) run_cmd(3'd2);
        chk("full_sp", sp, 8'h10);
        chk("full_depth", depth, 5'd16);
        run_cmd(3'd2);
        chk("overflow_sp", sp, 8'h10);
        for (int c = 6; c < 8; c++) run_cmd(3'(c));
        run_cmd(3'd0);

        // Reset in PUSH_DEC abandons the push
        run_cmd(3'd5);
        cmd = 3'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_pushdec_rsel", r_sel, 4'b0100);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_controls("abort_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_after_memwr", mem_wr, 1'b0);
        chk("abort_after_done", done, 1'b0);
        chk("abort_after_depth", depth, 5'd0);
        m_sp = m_sp - 8'h01;
        check_regs("abort");

        // Random command stream
        for (int k = 0; k < 300; k++) begin
            int r;
            logic [2:0] c;
            r = $urandom_range(0, 99);
            if      (r < 4)  c = 3'd0;
            else if (r < 18) c = 3'd1;
            else if (r < 48) c = 3'd2;
            else if (r < 74) c = 3'd3;
            else if (r < 86) c = 3'd4;
            else if (r < 90) c = 3'd5;
            else if (r < 95) c = 3'($urandom_range(6, 7));
            else begin
                preload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                c = 3'd0;
            end
            bus = 8'($urandom);
            run_cmd(c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arf_sequencer.md
ARF_SEQUENCER -- requirements
Module: arf_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 16: maximum number of outstanding pushes tracked by the sequencer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 cmd  input  3  command code: NOP, FETCH, PUSH, POP, JUMP, CLEAR.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-007 done  output  1  one-cycle pulse in the last cycle of a completed command.
REQ-008 err  output  1  one-cycle pulse for a rejected command.
REQ-009 funsel  output  2  ARF function: 00 clear, 01 load, 10 decrement, 11 increment.
REQ-010 r_sel  output  4  ARF enables, bit order {AR, SP, PC_past, PC}, active-high.
REQ-011 out_a_sel  output  2  ARF port A select: 00 AR, 01 SP, 10 PC_past, 11 PC.
REQ-012 out_b_sel  output  2  ARF port B select, same encoding as out_a_sel.
REQ-013 i_src  output  1  ARF input mux: 0 external data bus, 1 ARF out_a feedback.
REQ-014 mem_rd, mem_wr  output  1 each  memory strobes; the address is ARF out_a.
REQ-015 depth  output  log2(STACK_DEPTH)+1  current stack occupancy.

Function
REQ-016 Moore outputs: all ARF and memory controls are decoded from the state register only, and are stable for the whole cycle.
REQ-017 Idle controls: r_sel=0000, funsel=01, out_a_sel=11, out_b_sel=11, i_src=0, mem_rd=0, mem_wr=0.
REQ-018 cmd_ready=1 only in state IDLE.
REQ-019 A command is accepted when cmd_valid and cmd_ready are both 1; NOP is accepted with no effect and no done pulse.
REQ-020 FETCH sequence (3 cycles):
  - F_ADDR: out_a_sel=11, mem_rd=1.
  - F_SAVE: out_a_sel=11, i_src=1, r_sel=0010, funsel=01.
  - F_INC: r_sel=0001, funsel=11, done=1.
REQ-021 PUSH sequence:
  - PUSH_DEC: r_sel=0100, funsel=10.
  - PUSH_WR: out_a_sel=01, mem_wr=1, done=1; depth increments by 1.
REQ-022 POP sequence:
  - POP_RD: out_a_sel=01, mem_rd=1.
  - POP_INC: r_sel=0100, funsel=11, done=1; depth decrements by 1.
REQ-023 JUMP sequence:
  - J_SAVE: out_a_sel=11, i_src=1, r_sel=0010, funsel=01.
  - J_LOAD: i_src=0, r_sel=0001, funsel=01, done=1.
REQ-024 CLEAR sequence (1 cycle): r_sel=1111, funsel=00, done=1; depth becomes 0.
REQ-025 Full/empty rejection: PUSH with depth=STACK_DEPTH, or POP with depth=0, is accepted but rejected. The sequencer stays in IDLE, issues no ARF enable, pulses err for 1 cycle, and does not pulse done.
REQ-026 Undefined cmd codes are rejected with an err pulse and no ARF enable.
REQ-027 Every sequence returns to IDLE after its done cycle; back-to-back commands have 1 IDLE cycle between them.
REQ-028 depth never wraps; it saturates at 0 and STACK_DEPTH through the rejection rules of REQ-025.

Reset
REQ-029 rst_n=0 at a rising edge forces IDLE, depth=0, done=0, err=0 and idle controls, including mid-sequence; the interrupted command is abandoned.
REQ-030 Reset does not clear ARF contents; software issues CLEAR for that.

Structure
REQ-031 A shared package holds the state enum, cmd codes, funsel codes, r_sel bit masks and out_sel codes.
REQ-032 Sub-module arf_depth_counter, an up/down saturating counter with full/empty flags.

Verification
REQ-033 Reset, then CLEAR -> done on the 1st active cycle with r_sel=1111, funsel=00; depth=0.
REQ-034 FETCH with PC=0x10 -> mem address 0x10 with mem_rd; then PC_past=0x10, PC=0x11; done in cycle 3.
REQ-035 16 PUSHes from SP=0x20 -> SP=0x10, depth=16; a 17th PUSH -> err pulse and SP unchanged.
REQ-036 POP at depth=0 -> err and no r_sel activity; after PUSH then POP -> SP restored and depth=0.
REQ-037 JUMP with external bus=0x80 and PC=0x05 -> PC_past=0x05, PC=0x80, done in cycle 2.
REQ-038 rst_n low during PUSH_DEC -> next cycle IDLE, no mem_wr, depth unchanged at 0.
